// File: rtl/fc_layer.sv
// Dense output stage: streams Q8.8 features, MACs each against N_OUT stored weights, emits
// N_OUT saturated scores serially. Define FC_RELU_EN to clamp negative scores to zero.
module fc_layer #(
  parameter int N_IN  = 1350,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_loaded,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [7:0]    out_idx,
  output logic          out_last,
  output logic          done
);

  localparam int DEPTH = N_IN * N_OUT;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(N_IN + 1);
  localparam int CW    = $clog2(N_OUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_MAC  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]               state;
  logic [AW-1:0]            w_ptr;
  logic [AW-1:0]            base;
  logic [AW-1:0]            rd_addr;
  logic [FW-1:0]            feat_cnt;
  logic [CW-1:0]            mac_cnt;
  logic [7:0]               out_k;
  logic signed [DW-1:0]     feature;
  logic signed [DW-1:0]     rdata;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  acc [N_OUT];
  logic signed [ACC_W-1:0]  sel;
  logic signed [ACC_W-1:0]  shifted;
  logic [DW-1:0]            sat;
  logic [DW-1:0]            score;
  logic [DW-1:0]            ram [DEPTH];

  logic accept, mac_last, feat_last, out_fire, out_k_last, ram_we;

  assign in_ready   = ((state == ST_IDLE) && w_loaded) || (state == ST_WAIT);
  assign accept     = in_valid && in_ready;
  assign ram_we     = (state == ST_IDLE) && w_valid;
  assign rd_addr    = base + AW'(mac_cnt);
  assign prod       = feature * rdata;
  assign mac_last   = (mac_cnt == CW'(N_OUT));
  assign feat_last  = (feat_cnt == FW'(N_IN - 1));
  assign out_valid  = (state == ST_OUT);
  assign out_fire   = out_valid && out_ready;
  assign out_k_last = (out_k == 8'(N_OUT - 1));

  // NOTE: the weight RAM has no reset port so it maps onto block RAM; w_loaded guards stale contents.
  always_ff @(posedge clk) begin
    if (ram_we) ram[w_ptr] <= w_data;
    rdata <= ram[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      w_ptr    <= '0;
      w_loaded <= 1'b0;
      base     <= '0;
      feat_cnt <= '0;
      mac_cnt  <= '0;
      out_k    <= '0;
      feature  <= '0;
      done     <= 1'b0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_valid) begin
            if (w_ptr == AW'(DEPTH - 1)) begin
              w_ptr    <= '0;
              w_loaded <= 1'b1;
            end else begin
              w_ptr <= w_ptr + AW'(1);
            end
          end
          if (accept) begin
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
            feat_cnt <= '0;
            base     <= '0;
            mac_cnt  <= '0;
            feature  <= in_data;
            state    <= ST_MAC;
          end
        end
        ST_WAIT: begin
          if (accept) begin
            mac_cnt <= '0;
            feature <= in_data;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Weight j is read in cycle j and consumed one cycle later.
          for (int j = 0; j < N_OUT; j++)
            if (mac_cnt == CW'(j + 1)) acc[j] <= acc[j] + ACC_W'(prod);
          if (mac_last) begin
            feat_cnt <= feat_cnt + FW'(1);
            base     <= base + AW'(N_OUT);
            out_k    <= '0;
            state    <= feat_last ? ST_OUT : ST_WAIT;
          end else begin
            mac_cnt <= mac_cnt + CW'(1);
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            if (out_k_last) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              out_k <= out_k + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int j = 0; j < N_OUT; j++)
      if (out_k == 8'(j)) sel = acc[j];
  end

  assign shifted = sel >>> FRAC;

  always_comb begin
    if (shifted > SAT_MAX)      sat = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[DW-1:0];
    else                        sat = shifted[DW-1:0];
  end

`ifdef FC_RELU_EN
  assign score = sat[DW-1] ? '0 : sat;
`else
  assign score = sat;
`endif

  assign out_data = out_valid ? score : '0;
  assign out_idx  = out_valid ? out_k : '0;
  assign out_last = out_valid && out_k_last;

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer (N_IN=4, N_OUT=2): directed and random frames against a
// sum-of-products reference model; honours FC_RELU_EN for expected scores.
module tb_fc_layer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int NW    = N_IN * N_OUT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          w_loaded;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [7:0]    out_idx;
  logic          out_last;
  logic          done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] wts   [NW];
  logic [15:0] feats [N_IN];
  logic [15:0] exp_sc[N_OUT];
  logic [15:0] first_sc[N_OUT];

  fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_data(w_data), .w_loaded(w_loaded),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: score[n] = clamp(floor(sum_f feat[f]*w[f][n] / 2^FRAC)), optional ReLU.
  function automatic void model();
    for (int n = 0; n < N_OUT; n++) begin
      longint s = 0;
      for (int f = 0; f < N_IN; f++)
        s += longint'($signed(feats[f])) * longint'($signed(wts[f*N_OUT+n]));
      s = s >>> FRAC;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      exp_sc[n] = 16'(s);
    end
  endfunction

  task automatic load_weights();
    @(negedge clk);
    for (int i = 0; i < NW; i++) begin
      w_valid = 1'b1;
      w_data  = wts[i];
      @(negedge clk);
    end
    w_valid = 1'b0;
    check("w_loaded_after_load", w_loaded, 1);
  endtask

  task automatic run_frame(input bit stall, input bit junk);
    int t;
    int lo;
    int done_cnt;
    model();
    for (int f = 0; f < N_IN; f++) begin
      in_valid = 1'b1;
      in_data  = feats[f];
      w_valid  = junk && (f > 0);
      w_data   = 16'($urandom);
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("in_ready_timeout", 0, 1);
      @(negedge clk);
      if (f < N_IN - 1) in_data = feats[f+1];
      else in_valid = 1'b0;
      lo = 0;
      while (!in_ready && !out_valid && lo < 100) begin
        lo++;
        w_valid = junk;
        w_data  = 16'($urandom);
        @(negedge clk);
      end
      if (f == N_IN - 1) w_valid = 1'b0;
      check($sformatf("in_ready_low_f%0d", f), lo, N_OUT + 1);
    end
    w_valid   = 1'b0;
    in_valid  = 1'b0;
    out_ready = !stall;
    done_cnt  = 0;
    for (int k = 0; k < N_OUT; k++) begin
      t = 0;
      while (!out_valid && t < 100) begin
        if (done) done_cnt++;
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("out_valid_timeout", 0, 1);
      if (stall && k == 0) begin
        repeat (5) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_sc[0]);
          check("stall_idx", out_idx, 0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      if (done) done_cnt++;
      check($sformatf("idx_k%0d", k), out_idx, k);
      check($sformatf("score_k%0d", k), out_data, exp_sc[k]);
      check($sformatf("last_k%0d", k), out_last, (k == N_OUT - 1));
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("out_valid_after", out_valid, 0);
    done_cnt += int'(done);
    @(negedge clk);
    done_cnt += int'(done);
    check("done_count", done_cnt, 1);
    out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_w_loaded"}, w_loaded, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Features offered before weights are loaded must not be consumed.
    in_valid = 1'b1;
    in_data  = 16'h0100;
    repeat (3) begin
      @(negedge clk);
      check("no_weights_in_ready", in_ready, 0);
      check("no_weights_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // Unit weights, features 1..4 with a stalled consumer, then a second frame with junk writes.
    for (int i = 0; i < NW; i++) wts[i] = 16'h0100;
    for (int f = 0; f < N_IN; f++) feats[f] = 16'((f + 1) * 256);
    load_weights();
    run_frame(1'b1, 1'b0);
    for (int n = 0; n < N_OUT; n++) first_sc[n] = exp_sc[n];
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);

    // Positive and negative saturation.
    for (int i = 0; i < NW; i++) wts[i] = 16'h7FFF;
    for (int f = 0; f < N_IN; f++) feats[f] = 16'h7FFF;
    load_weights();
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < NW; i++) wts[i] = 16'h8000;
    load_weights();
    run_frame(1'b0, 1'b0);

    // Neuron 1 weighted -1.0, neuron 0 +1.0.
    for (int f = 0; f < N_IN; f++) begin
      wts[f*N_OUT]     = 16'h0100;
      wts[f*N_OUT + 1] = 16'hFF00;
      feats[f]         = 16'h0100;
    end
    load_weights();
    run_frame(1'b0, 1'b0);

    // Random frames: small values (no saturation) and full-range values.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++)
        wts[i] = (r < 3) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
      for (int f = 0; f < N_IN; f++)
        feats[f] = (r < 3) ? 16'($urandom_range(0, 2047) - 1024) : 16'($urandom);
      load_weights();
      run_frame(r[0], r[1]);
    end

    // Asynchronous reset mid-frame aborts it and forces a weight reload.
    in_valid = 1'b1;
    in_data  = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midrun_reset");
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 0);
    check("post_reset_out_valid", out_valid, 0);
    in_valid = 1'b0;
    for (int i = 0; i < NW; i++) wts[i] = 16'($urandom_range(0, 1023) - 512);
    for (int f = 0; f < N_IN; f++) feats[f] = 16'($urandom_range(0, 2047) - 1024);
    load_weights();
    run_frame(1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
